// File: rtl/indirect_normal_accum_pkg.sv
// Shared configuration for the indirect-branch normal-equation accumulator.
// Holds the default field widths of the indirect calculation pipeline, the
// accumulator/counter sizes, the output word count, the FSM state type and
// the mapping from output word index to its (row, col) in the 6x6 upper
// triangle of H.
package indirect_normal_accum_pkg;

  localparam int ID_COE_BW  = 16;   // Jacobian coefficient width
  localparam int H_SIZE_BW  = 10;   // horizontal image coordinate width
  localparam int V_SIZE_BW  = 9;    // vertical image coordinate width

  localparam int NE_ACC_BW  = 64;
  localparam int NE_CNT_BW  = 20;
  localparam int NE_WORDS   = 28;   // 21 H entries + 6 b entries + count
  localparam int NE_H_WORDS = 21;
  localparam int NE_ACC_NUM = 27;

  typedef enum logic [1:0] {
    NE_IDLE,
    NE_ACCUM,
    NE_FLUSH,
    NE_DRAIN
  } ne_state_e;

  // Word index (0..20) -> {row[2:0], col[2:0]} of the row-major upper triangle.
  function automatic logic [5:0] ne_word_rc(input int idx);
    int k;
    logic [5:0] rc;
    k  = 0;
    rc = '0;
    for (int r = 0; r < 6; r++) begin
      for (int c = r; c < 6; c++) begin
        if (k == idx) rc = {3'(r), 3'(c)};
        k++;
      end
    end
    return rc;
  endfunction

endpackage

// File: rtl/indirect_normal_accum_sat_accum.sv
// Registered signed saturating accumulator.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clears the sum and the saturation flag (wins over i_en)
//   i_en           : adds i_data into the sum
//   i_data         : signed addend, already sign-extended to ACC_BW
//   o_acc          : running sum, clamped to the signed ACC_BW range
//   o_sat          : sticky, set once any addition had to clamp
module indirect_normal_accum_sat_accum #(
  parameter int ACC_BW = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [ACC_BW-1:0] i_data,
  output logic signed [ACC_BW-1:0] o_acc,
  output logic                     o_sat
);

  localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

  // Returns {clamped, sum}. Overflow shows as a disagreement between the
  // guard bit and the sign bit of the one-bit-wider sum.
  function automatic logic [ACC_BW:0] sat_add(input logic signed [ACC_BW-1:0] a,
                                               input logic signed [ACC_BW-1:0] b);
    logic signed [ACC_BW:0] s;
    s = {a[ACC_BW-1], a} + {b[ACC_BW-1], b};
    if (s[ACC_BW] != s[ACC_BW-1])
      return {1'b1, (s[ACC_BW] ? ACC_MIN : ACC_MAX)};
    return {1'b0, s[ACC_BW-1:0]};
  endfunction

  logic [ACC_BW:0] nxt;
  assign nxt = sat_add(o_acc, i_data);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_acc <= '0;
      o_sat <= 1'b0;
    end else if (i_clr) begin
      o_acc <= '0;
      o_sat <= 1'b0;
    end else if (i_en) begin
      o_acc <= nxt[ACC_BW-1:0];
      o_sat <= o_sat | nxt[ACC_BW];
    end
  end

endmodule

// File: rtl/indirect_normal_accum.sv
// Per-frame normal-equation accumulator for the indirect (feature) branch.
// Accumulates H = sum(Ax*Ax' + Ay*Ay') (upper triangle, 21 entries),
// b = sum(Ax*dx + Ay*dy) and the sample count, then streams 28 words out.
//   i_clk, i_rst_n              : clock, asynchronous active-low reset
//   i_frame_start / i_frame_end : open (clear) / close a frame
//   i_valid, i_Ax_*, i_Ay_*,
//   i_diffs_x, i_diffs_y        : one correspondence sample per strobe
//   o_mat_valid/i_mat_ready     : output word handshake
//   o_mat_idx, o_mat_data       : word index 0..27 and its value
//   o_busy, o_done              : not idle / one-cycle end-of-drain pulse
//   o_ovf, o_err                : sticky saturation / protocol error flags
module indirect_normal_accum
  import indirect_normal_accum_pkg::*;
#(
  parameter int COE_BW = ID_COE_BW,
  parameter int DX_BW  = H_SIZE_BW + 1,
  parameter int DY_BW  = V_SIZE_BW + 1,
  parameter int ACC_BW = NE_ACC_BW,
  parameter int CNT_BW = NE_CNT_BW
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_frame_start,
  input  logic                     i_frame_end,
  input  logic                     i_valid,
  input  logic signed [COE_BW-1:0] i_Ax_0,
  input  logic signed [COE_BW-1:0] i_Ax_1,
  input  logic signed [COE_BW-1:0] i_Ax_2,
  input  logic signed [COE_BW-1:0] i_Ax_3,
  input  logic signed [COE_BW-1:0] i_Ax_4,
  input  logic signed [COE_BW-1:0] i_Ax_5,
  input  logic signed [COE_BW-1:0] i_Ay_0,
  input  logic signed [COE_BW-1:0] i_Ay_1,
  input  logic signed [COE_BW-1:0] i_Ay_2,
  input  logic signed [COE_BW-1:0] i_Ay_3,
  input  logic signed [COE_BW-1:0] i_Ay_4,
  input  logic signed [COE_BW-1:0] i_Ay_5,
  input  logic signed [DX_BW-1:0]  i_diffs_x,
  input  logic signed [DY_BW-1:0]  i_diffs_y,
  output logic                     o_mat_valid,
  input  logic                     i_mat_ready,
  output logic [4:0]               o_mat_idx,
  output logic signed [ACC_BW-1:0] o_mat_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_ovf,
  output logic                     o_err
);

  localparam int H_BW  = 2 * COE_BW;
  localparam int BP_BW = COE_BW + ((DX_BW > DY_BW) ? DX_BW : DY_BW);

  ne_state_e state;
  logic [1:0]        flush_cnt;
  logic [CNT_BW-1:0] cnt;
  logic              frame_clr, take;
  logic              vld_p0, vld_p1, vld_p2;

  logic signed [COE_BW-1:0] ax_p0 [6];
  logic signed [COE_BW-1:0] ay_p0 [6];
  logic signed [DX_BW-1:0]  dx_p0;
  logic signed [DY_BW-1:0]  dy_p0;

  logic signed [ACC_BW-1:0] acc_q [NE_ACC_NUM];
  logic [NE_ACC_NUM-1:0]    sat_q;

  // A frame start is honoured only while idle or accumulating; it also
  // kills old-frame samples still in flight in the pipeline.
  assign frame_clr = i_frame_start & ((state == NE_IDLE) | (state == NE_ACCUM));
  assign take      = i_valid & (state == NE_ACCUM);

  // ---- S1: input registers ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      dx_p0  <= '0;
      dy_p0  <= '0;
      for (int k = 0; k < 6; k++) begin
        ax_p0[k] <= '0;
        ay_p0[k] <= '0;
      end
    end else begin
      vld_p0 <= take;
      vld_p1 <= vld_p0 & ~frame_clr;
      vld_p2 <= vld_p1 & ~frame_clr;
      if (take) begin
        ax_p0 <= '{i_Ax_0, i_Ax_1, i_Ax_2, i_Ax_3, i_Ax_4, i_Ax_5};
        ay_p0 <= '{i_Ay_0, i_Ay_1, i_Ay_2, i_Ay_3, i_Ay_4, i_Ay_5};
        dx_p0 <= i_diffs_x;
        dy_p0 <= i_diffs_y;
      end
    end
  end

  // ---- S2: products / S3: pair sums / accumulate, H upper triangle ----
  for (genvar k = 0; k < NE_H_WORDS; k++) begin : g_h
    localparam logic [5:0] RC = ne_word_rc(k);
    localparam int R = int'(RC[5:3]);
    localparam int C = int'(RC[2:0]);
    logic signed [H_BW-1:0] hx_p1, hy_p1;
    logic signed [H_BW:0]   hs_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        hx_p1 <= '0;
        hy_p1 <= '0;
        hs_p2 <= '0;
      end else begin
        if (vld_p0) begin
          hx_p1 <= H_BW'(ax_p0[R]) * H_BW'(ax_p0[C]);
          hy_p1 <= H_BW'(ay_p0[R]) * H_BW'(ay_p0[C]);
        end
        if (vld_p1) hs_p2 <= (H_BW+1)'(hx_p1) + (H_BW+1)'(hy_p1);
      end
    end

    indirect_normal_accum_sat_accum #(.ACC_BW(ACC_BW)) u_acc (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_clr  (frame_clr),
      .i_en   (vld_p2),
      .i_data (ACC_BW'(hs_p2)),
      .o_acc  (acc_q[k]),
      .o_sat  (sat_q[k])
    );
  end

  // ---- S2: products / S3: pair sums / accumulate, b vector ----
  for (genvar i = 0; i < 6; i++) begin : g_b
    logic signed [BP_BW-1:0] bx_p1, by_p1;
    logic signed [BP_BW:0]   bs_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        bx_p1 <= '0;
        by_p1 <= '0;
        bs_p2 <= '0;
      end else begin
        if (vld_p0) begin
          bx_p1 <= BP_BW'(ax_p0[i]) * BP_BW'(dx_p0);
          by_p1 <= BP_BW'(ay_p0[i]) * BP_BW'(dy_p0);
        end
        if (vld_p1) bs_p2 <= (BP_BW+1)'(bx_p1) + (BP_BW+1)'(by_p1);
      end
    end

    indirect_normal_accum_sat_accum #(.ACC_BW(ACC_BW)) u_acc (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_clr  (frame_clr),
      .i_en   (vld_p2),
      .i_data (ACC_BW'(bs_p2)),
      .o_acc  (acc_q[NE_H_WORDS+i]),
      .o_sat  (sat_q[NE_H_WORDS+i])
    );
  end

  // Sample counter, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      cnt <= '0;
    else if (frame_clr)
      cnt <= {{(CNT_BW-1){1'b0}}, take};
    else if (take && (cnt != '1))
      cnt <= cnt + CNT_BW'(1);
  end

  // Control FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= NE_IDLE;
      flush_cnt   <= '0;
      o_mat_valid <= 1'b0;
      o_mat_idx   <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        NE_IDLE: begin
          if (i_frame_start) begin
            state <= NE_ACCUM;
            o_err <= 1'b0;
          end
        end
        NE_ACCUM: begin
          if (i_frame_start) begin
            o_err <= 1'b0;
          end else if (i_frame_end) begin
            state     <= NE_FLUSH;
            flush_cnt <= '0;
          end
        end
        NE_FLUSH: begin
          if (i_valid) o_err <= 1'b1;
          if (flush_cnt == 2'd2) begin
            state       <= NE_DRAIN;
            o_mat_valid <= 1'b1;
            o_mat_idx   <= '0;
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end
        NE_DRAIN: begin
          if (i_valid || i_frame_start) o_err <= 1'b1;
          if (i_mat_ready) begin
            if (o_mat_idx == 5'(NE_WORDS - 1)) begin
              state       <= NE_IDLE;
              o_mat_valid <= 1'b0;
              o_mat_idx   <= '0;
              o_done      <= 1'b1;
            end else begin
              o_mat_idx <= o_mat_idx + 5'd1;
            end
          end
        end
        default: state <= NE_IDLE;
      endcase
    end
  end

  // The word mux reads the accumulators directly: the last sample of a frame
  // lands in them on the same edge that enters DRAIN, so a word register
  // loaded on that edge would miss it.
  always_comb begin
    o_mat_data = '0;
    if (state == NE_DRAIN) begin
      if (o_mat_idx == 5'(NE_WORDS - 1))
        o_mat_data = ACC_BW'(cnt);
      else
        o_mat_data = acc_q[o_mat_idx];
    end
  end

  assign o_busy = (state != NE_IDLE);
  assign o_ovf  = |sat_q;

endmodule

// File: tb/tb_indirect_normal_accum.sv
// Directed bench for indirect_normal_accum: a default-width instance plus a
// narrow-accumulator instance (ACC_BW = 2*COE_BW+2) sharing the same stimulus.
module tb_indirect_normal_accum;
  import indirect_normal_accum_pkg::*;

  localparam int CW     = ID_COE_BW;
  localparam int DXW    = H_SIZE_BW + 1;
  localparam int DYW    = V_SIZE_BW + 1;
  localparam int SAT_BW = 2 * CW + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_start, frame_end, valid, mat_ready;
  logic signed [CW-1:0]  ax [6];
  logic signed [CW-1:0]  ay [6];
  logic signed [DXW-1:0] dx;
  logic signed [DYW-1:0] dy;

  logic                     mat_valid1, busy1, done1, ovf1, err1;
  logic [4:0]               idx1;
  logic signed [63:0]       data1;
  logic                     mat_valid2, busy2, done2, ovf2, err2;
  logic [4:0]               idx2;
  logic signed [SAT_BW-1:0] data2;

  int n_chk = 0;
  int n_fail = 0;
  longint exp_w [NE_WORDS];
  longint got1  [NE_WORDS];
  longint got2  [NE_WORDS];
  int cur_ax [6];
  int cur_ay [6];
  int cur_dx, cur_dy;

  always #5 clk = ~clk;

  indirect_normal_accum dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_frame_end(frame_end),
    .i_valid(valid),
    .i_Ax_0(ax[0]), .i_Ax_1(ax[1]), .i_Ax_2(ax[2]), .i_Ax_3(ax[3]), .i_Ax_4(ax[4]), .i_Ax_5(ax[5]),
    .i_Ay_0(ay[0]), .i_Ay_1(ay[1]), .i_Ay_2(ay[2]), .i_Ay_3(ay[3]), .i_Ay_4(ay[4]), .i_Ay_5(ay[5]),
    .i_diffs_x(dx), .i_diffs_y(dy),
    .o_mat_valid(mat_valid1), .i_mat_ready(mat_ready), .o_mat_idx(idx1), .o_mat_data(data1),
    .o_busy(busy1), .o_done(done1), .o_ovf(ovf1), .o_err(err1)
  );

  indirect_normal_accum #(.ACC_BW(SAT_BW)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_frame_end(frame_end),
    .i_valid(valid),
    .i_Ax_0(ax[0]), .i_Ax_1(ax[1]), .i_Ax_2(ax[2]), .i_Ax_3(ax[3]), .i_Ax_4(ax[4]), .i_Ax_5(ax[5]),
    .i_Ay_0(ay[0]), .i_Ay_1(ay[1]), .i_Ay_2(ay[2]), .i_Ay_3(ay[3]), .i_Ay_4(ay[4]), .i_Ay_5(ay[5]),
    .i_diffs_x(dx), .i_diffs_y(dy),
    .o_mat_valid(mat_valid2), .i_mat_ready(mat_ready), .o_mat_idx(idx2), .o_mat_data(data2),
    .o_busy(busy2), .o_done(done2), .o_ovf(ovf2), .o_err(err2)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 6; k++) begin
      ax[k] = CW'(cur_ax[k]);
      ay[k] = CW'(cur_ay[k]);
    end
    dx = DXW'(cur_dx);
    dy = DYW'(cur_dy);
  endtask

  task automatic model_clear();
    for (int k = 0; k < NE_WORDS; k++) exp_w[k] = 0;
  endtask

  task automatic model_add();
    int k;
    k = 0;
    for (int r = 0; r < 6; r++)
      for (int c = r; c < 6; c++) begin
        exp_w[k] += longint'(cur_ax[r]) * longint'(cur_ax[c])
                  + longint'(cur_ay[r]) * longint'(cur_ay[c]);
        k++;
      end
    for (int i = 0; i < 6; i++)
      exp_w[NE_H_WORDS+i] += longint'(cur_ax[i]) * longint'(cur_dx)
                           + longint'(cur_ay[i]) * longint'(cur_dy);
    exp_w[NE_WORDS-1] += 1;
  endtask

  task automatic send(input bit counted);
    drive_inputs();
    valid = 1'b1;
    if (counted) model_add();
    tick();
    valid = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  // Accepts all 28 words (ready held high or random ~30%), checking order,
  // values against exp_w and stability of idx/data while stalled.
  task automatic drain(input string tag, input bit rnd);
    int nxt, cyc;
    bit stalled;
    longint sidx, sdat;
    nxt = 0; cyc = 0; stalled = 0; sidx = 0; sdat = 0;
    while (nxt < NE_WORDS && cyc < 3000) begin
      mat_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (mat_valid1) begin
        if (stalled) begin
          chk({tag, "_hold_idx"}, longint'(idx1), sidx);
          chk({tag, "_hold_data"}, data1, sdat);
        end
        if (mat_ready) begin
          chk($sformatf("%s_idx%0d", tag, nxt), longint'(idx1), longint'(nxt));
          chk($sformatf("%s_w%0d", tag, nxt), data1, exp_w[nxt]);
          got1[nxt] = data1;
          got2[nxt] = data2;
          nxt++;
          stalled = 0;
        end else begin
          stalled = 1;
          sidx = longint'(idx1);
          sdat = data1;
        end
      end
      tick();
      cyc++;
    end
    mat_ready = 1'b0;
    chk({tag, "_words_seen"}, longint'(nxt), longint'(NE_WORDS));
    chk({tag, "_done_pulse"}, longint'(done1), 1);
    chk({tag, "_busy_at_done"}, longint'(busy1), 0);
    tick();
    chk({tag, "_done_single"}, longint'(done1), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; valid = 1'b0; mat_ready = 1'b0;
    cur_ax = '{0, 0, 0, 0, 0, 0}; cur_ay = '{0, 0, 0, 0, 0, 0}; cur_dx = 0; cur_dy = 0;
    drive_inputs();
    tick(); tick();
    chk("rst_valid", longint'(mat_valid1), 0);
    chk("rst_idx",   longint'(idx1), 0);
    chk("rst_data",  data1, 0);
    chk("rst_busy",  longint'(busy1), 0);
    chk("rst_done",  longint'(done1), 0);
    chk("rst_ovf",   longint'(ovf1), 0);
    chk("rst_err",   longint'(err1), 0);
    rst_n = 1'b1;
    tick();

    // T1: single sample
    model_clear();
    cur_ax = '{1, 2, 3, 4, 5, 6}; cur_ay = '{0, 0, 0, 0, 0, 0}; cur_dx = 2; cur_dy = 0;
    start_frame();
    chk("t1_busy", longint'(busy1), 1);
    send(1);
    end_frame();
    drain("t1", 0);
    chk("t1_h00", got1[0], 1);
    chk("t1_h05", got1[5], 6);
    chk("t1_h55", got1[20], 36);
    for (int i = 0; i < 6; i++) chk($sformatf("t1_b%0d", i), got1[21+i], longint'(2 * (i + 1)));
    chk("t1_cnt", got1[27], 1);

    // T2: 1000 back-to-back samples
    for (int k = 0; k < NE_WORDS - 1; k++) exp_w[k] = 2000;
    exp_w[NE_WORDS-1] = 1000;
    cur_ax = '{1, 1, 1, 1, 1, 1}; cur_ay = '{1, 1, 1, 1, 1, 1}; cur_dx = -1; cur_dy = 3;
    start_frame();
    drive_inputs();
    valid = 1'b1;
    repeat (1000) tick();
    valid = 1'b0;
    end_frame();
    drain("t2", 0);
    chk("t2_ovf", longint'(ovf1), 0);

    // T3: sample on frame_end counted, sample at t+2 dropped with error
    model_clear();
    start_frame();
    cur_ax = '{3, -1, 0, 2, 5, -4}; cur_ay = '{1, 1, -2, 0, 3, 7}; cur_dx = 10; cur_dy = -7;
    send(1);
    cur_ax = '{-8, 4, 4, 1, 0, 2}; cur_ay = '{0, -3, 6, 2, 2, -1}; cur_dx = -20; cur_dy = 5;
    send(1);
    cur_ax = '{2, 2, -5, 9, 1, 0}; cur_ay = '{4, 0, 1, -1, -6, 3}; cur_dx = 7; cur_dy = 11;
    drive_inputs();
    frame_end = 1'b1; valid = 1'b1; model_add();
    tick();
    frame_end = 1'b0; valid = 1'b0;
    chk("t3_err_before_drop", longint'(err1), 0);
    tick();
    cur_ax = '{100, 100, 100, 100, 100, 100};
    drive_inputs();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("t3_err_set", longint'(err1), 1);
    chk("t3_no_valid_t3", longint'(mat_valid1), 0);
    tick();
    chk("t3_valid_t4", longint'(mat_valid1), 1);
    drain("t3", 0);
    chk("t3_err_sticky", longint'(err1), 1);

    // T4: restart inside ACCUM, extreme values, random ready
    start_frame();
    chk("t4_err_cleared", longint'(err1), 0);
    model_clear();
    cur_ax = '{50, 50, 50, 50, 50, 50}; cur_ay = '{9, 9, 9, 9, 9, 9}; cur_dx = 3; cur_dy = 3;
    send(0);
    cur_ax = '{-32768, 32767, 1, -1, 0, 12}; cur_ay = '{32767, -32768, 5, 5, -7, 0};
    cur_dx = -1024; cur_dy = 511;
    drive_inputs();
    frame_start = 1'b1; valid = 1'b1;
    model_clear(); model_add();
    tick();
    frame_start = 1'b0; valid = 1'b0;
    cur_ax = '{7, -7, 300, -300, 2, 1}; cur_ay = '{-1, 0, 1, 1000, -1000, 4}; cur_dx = 1023; cur_dy = -512;
    send(1);
    cur_ax = '{32767, 32767, -32768, 4, 4, 4}; cur_ay = '{0, 1, 2, 3, 4, 5}; cur_dx = 17; cur_dy = -3;
    send(1);
    cur_ax = '{-2, -4, -6, -8, -10, -12}; cur_ay = '{1, 3, 5, 7, 9, 11}; cur_dx = 0; cur_dy = 100;
    send(1);
    end_frame();
    drain("t4", 1);
    chk("t4_ovf", longint'(ovf1), 0);

    // T5: max-magnitude coefficients saturate the narrow instance
    model_clear();
    cur_ax = '{-32768, -32768, -32768, -32768, -32768, -32768};
    cur_ay = '{-32768, -32768, -32768, -32768, -32768, -32768};
    cur_dx = 0; cur_dy = 0;
    start_frame();
    repeat (5) send(1);
    end_frame();
    drain("t5", 0);
    chk("t5_sat_h00", got2[0], 64'sd8589934591);
    chk("t5_sat_h55", got2[20], 64'sd8589934591);
    chk("t5_sat_b0", got2[21], 0);
    chk("t5_sat_cnt", got2[27], 5);
    chk("t5_sat_ovf", longint'(ovf2), 1);
    chk("t5_wide_ovf", longint'(ovf1), 0);

    // T6: reset in the middle of the drain, then a clean frame
    start_frame();
    chk("t6_ovf_cleared", longint'(ovf2), 0);
    cur_ax = '{1, 1, 2, 2, 3, 3}; cur_ay = '{0, 1, 0, 1, 0, 1}; cur_dx = 4; cur_dy = 4;
    send(0);
    end_frame();
    mat_ready = 1'b1;
    cyc = 0;
    while (!(mat_valid1 && idx1 == 5'd10) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("t6_reached_w10", longint'(idx1), 10);
    rst_n = 1'b0;
    tick();
    mat_ready = 1'b0;
    chk("t6_rst_valid", longint'(mat_valid1), 0);
    chk("t6_rst_idx",   longint'(idx1), 0);
    chk("t6_rst_data",  data1, 0);
    chk("t6_rst_busy",  longint'(busy1), 0);
    chk("t6_rst_done",  longint'(done1), 0);
    chk("t6_rst_ovf",   longint'(ovf1), 0);
    chk("t6_rst_err",   longint'(err1), 0);
    rst_n = 1'b1;
    mat_ready = 1'b1;
    tick(); tick();
    chk("t6_no_words_after_rst", longint'(mat_valid1), 0);
    mat_ready = 1'b0;
    model_clear();
    start_frame();
    cur_ax = '{-3, 0, 7, 1, -2, 5}; cur_ay = '{2, 2, -1, 0, 4, -6}; cur_dx = -5; cur_dy = 9;
    send(1);
    end_frame();
    drain("t6", 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
